// File: rtl/game_pkg.sv
// Shared game-flow types and default sizing for the result controller, banner and board modules.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        ENDED = 2'd1,
        CLEAR = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_WHITE = 2'd1,
        RES_BLACK = 2'd2,
        RES_TIE   = 2'd3
    } game_result_t;

    localparam int unsigned DEF_MAX_MOVES    = 225;
    localparam int unsigned DEF_ANIM_FRAMES  = 64;
    localparam int unsigned DEF_CLEAR_FRAMES = 2;

    function automatic game_result_t side_result(input logic is_white);
        return is_white ? RES_WHITE : RES_BLACK;
    endfunction

endpackage

// File: rtl/key_rise_detect.sv
// Turns a held key level into a single-frame pulse on its rising edge.
module key_rise_detect (
    input  logic frame_clk,
    input  logic Reset,
    input  logic key_i,
    output logic rise_o
);

    logic key_prev_q;

    // Previous level is captured every frame regardless of what the consumer is doing.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_i;
        end
    end

    assign rise_o = key_i & ~key_prev_q;

endmodule

// File: rtl/game_result_ctrl.sv
// Game-outcome controller: turn/move tracking, win/tie decision, banner hold and restart sequencing.
module game_result_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MAX_MOVES      = DEF_MAX_MOVES,
    parameter int unsigned ANIM_FRAMES    = DEF_ANIM_FRAMES,
    parameter int unsigned CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
    parameter bit          FIRST_IS_WHITE = 1'b0,
    localparam int unsigned MCW           = $clog2(MAX_MOVES + 1)
) (
    input  logic           frame_clk,
    input  logic           Reset,
    input  logic           move_done_i,
    input  logic           white_line_i,
    input  logic           black_line_i,
    input  logic           r_pressed_i,
    output logic           accept_move_o,
    output logic           white_turn_o,
    output logic [MCW-1:0] move_count_o,
    output logic           is_ending_exist_o,
    output logic           white_win_o,
    output logic           black_win_o,
    output logic           tie_o,
    output logic           board_clear_o
);

    localparam int unsigned HW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int unsigned CW = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;

    localparam logic [HW-1:0]  HOLD_INIT  = HW'(ANIM_FRAMES - 1);
    localparam logic [CW-1:0]  CLEAR_INIT = CW'(CLEAR_FRAMES - 1);
    localparam logic [MCW-1:0] MAX_COUNT  = MCW'(MAX_MOVES);

    game_state_t    state_q,      state_d;
    game_result_t   result_q,     result_d;
    logic           white_turn_q, white_turn_d;
    logic [MCW-1:0] move_count_q, move_count_d;
    logic [HW-1:0]  hold_q,       hold_d;
    logic [CW-1:0]  clear_cnt_q,  clear_cnt_d;

    logic           r_rise;
    logic           mover_line;
    logic           other_line;
    logic [MCW-1:0] count_inc;
    logic [MCW-1:0] count_sat;
    logic           last_move;

    key_rise_detect u_r_rise (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .key_i     (r_pressed_i),
        .rise_o    (r_rise)
    );

    assign mover_line = white_turn_q ? white_line_i : black_line_i;
    assign other_line = white_turn_q ? black_line_i : white_line_i;
    assign count_inc  = move_count_q + MCW'(1);
    assign count_sat  = (move_count_q == MAX_COUNT) ? MAX_COUNT : count_inc;
    assign last_move  = (count_inc == MAX_COUNT);

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        white_turn_d = white_turn_q;
        move_count_d = move_count_q;
        hold_d       = hold_q;
        clear_cnt_d  = clear_cnt_q;

        unique case (state_q)
            PLAY: begin
                // A move in the same frame as a restart press wins; the press is dropped.
                if (move_done_i) begin
                    move_count_d = count_sat;
                    if (mover_line) begin
                        result_d = side_result(white_turn_q);
                    end else if (other_line) begin
                        result_d = side_result(~white_turn_q);
                    end else if (last_move) begin
                        result_d = RES_TIE;
                    end else begin
                        white_turn_d = ~white_turn_q;
                    end
                    if (mover_line || other_line || last_move) begin
                        state_d = ENDED;
                        hold_d  = HOLD_INIT;
                    end
                end else if (r_rise) begin
                    state_d     = CLEAR;
                    clear_cnt_d = CLEAR_INIT;
                end
            end

            ENDED: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (r_rise) begin
                    state_d     = CLEAR;
                    result_d    = RES_NONE;
                    clear_cnt_d = CLEAR_INIT;
                end
            end

            CLEAR: begin
                if (clear_cnt_q == '0) begin
                    state_d      = PLAY;
                    move_count_d = '0;
                    white_turn_d = FIRST_IS_WHITE;
                end else begin
                    clear_cnt_d = clear_cnt_q - CW'(1);
                end
            end

            default: begin
                state_d  = PLAY;
                result_d = RES_NONE;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= PLAY;
            result_q     <= RES_NONE;
            white_turn_q <= FIRST_IS_WHITE;
            move_count_q <= '0;
            hold_q       <= '0;
            clear_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            white_turn_q <= white_turn_d;
            move_count_q <= move_count_d;
            hold_q       <= hold_d;
            clear_cnt_q  <= clear_cnt_d;
        end
    end

    // Flags decode straight from registered state so they are glitch-free and mutually exclusive.
    assign accept_move_o     = (state_q == PLAY);
    assign board_clear_o     = (state_q == CLEAR);
    assign white_turn_o      = white_turn_q;
    assign move_count_o      = move_count_q;
    assign is_ending_exist_o = (result_q != RES_NONE);
    assign white_win_o       = (result_q == RES_WHITE);
    assign black_win_o       = (result_q == RES_BLACK);
    assign tie_o             = (result_q == RES_TIE);

endmodule
